// File: rtl/down_counter_ctrl.sv
// Down-counter sequencing controller: load, prescaled decrement, pause/abort,
// optional auto-reload at terminal count. The count never wraps below zero.
//
// state | meaning
// IDLE  | waiting for start, cnt=0
// RUN   | counting, one decrement per PRESCALE cycles
// HOLD  | paused, cnt and prescale phase frozen
// DONE  | terminal count reached without reload, waiting for restart
module down_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             reload_mode,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [1:0]       state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pre_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        reload_d = load_val;
                        mode_d   = reload_mode;
                        cnt_d    = load_val;
                        pre_d    = '0;
                        if (load_val != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                // Releasing pause counts in the same cycle, so a pause of N
                // cycles stretches the run by exactly N cycles.
                RUN, HOLD: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (pre_q == PRE_LAST) begin
                            pre_d = '0;
                            if (cnt_q > WIDTH'(1)) begin
                                cnt_d = cnt_q - WIDTH'(1);
                            end else if (cnt_q == WIDTH'(1)) begin
                                tc_d = 1'b1;
                                if (mode_q) begin
                                    cnt_d = reload_q;
                                end else begin
                                    cnt_d   = '0;
                                    state_d = DONE;
                                end
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);
    assign state = state_q;

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
Sequencing controller for the down-counter datapath. It loads a start value, decrements once per prescaled tick, and pauses, aborts, or auto-reloads on command. It signals terminal count and guarantees the count never wraps below zero. It sits between a host or control FSM and the count register, presenting a start/pause/abort control interface.

Parameters:
WIDTH, 4, count width in bits (>=2)
PRESCALE, 1, clock cycles per decrement (>=1); the prescaler counter is sized to hold PRESCALE-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  load load_val and begin counting; honoured in IDLE and DONE only
load_val  input  WIDTH  start/reload value, sampled on an accepted start
reload_mode  input  1  sampled on an accepted start; 1 = auto-reload at terminal count
pause  input  1  level; freezes counting while high in RUN/HOLD
abort  input  1  return to IDLE from any state
cnt  output  WIDTH  current count (registered)
busy  output  1  high in RUN or HOLD
tc  output  1  one-cycle pulse, registered, on terminal-count event
done  output  1  high in DONE
state  output  2  IDLE=0, RUN=1, HOLD=2, DONE=3 (debug)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. The ports are named clk and rst.
- Reset value of every output:
  - state=IDLE, cnt=0, tc=0, busy=0, done=0.
  - Prescaler counter=0, latched reload value=0, latched mode=0.
- Priority each cycle: abort > start > pause > decrement.
- IDLE:
  - start=1 latches reload_val<=load_val and mode<=reload_mode, and sets cnt<=load_val and pre<=0.
  - Next state is RUN if load_val!=0.
  - If load_val==0: next state is DONE with tc=1 for one cycle and cnt=0.
- RUN:
  - pre increments each cycle. When pre==PRESCALE-1, a decrement event occurs and pre<=0.
  - Decrement event with cnt>1: cnt<=cnt-1.
  - Decrement event with cnt==1: tc<=1 (high during the cycle after the edge).
    - mode=1: cnt<=reload_val, stay in RUN.
    - mode=0: cnt<=0, go to DONE.
  - pause=1: go to HOLD. pre and cnt are frozen that cycle, so no decrement occurs even if the event would fire.
- HOLD:
  - cnt and pre hold.
  - pause=0: return to RUN, resuming the prescale phase where it stopped.
  - start is ignored.
- DONE:
  - done=1, cnt=0, holds indefinitely.
  - start behaves exactly as in IDLE (restart); pause is ignored.
- abort (any state): next state IDLE, cnt<=0, pre<=0, tc<=0. A start in the same cycle is ignored.
- start in RUN or HOLD is ignored: no reload, no phase change.
- tc is low in every cycle except the single cycle following a terminal-count edge.
  - In auto-reload mode it pulses once per period.
- No underflow: cnt never transitions 0 -> all-ones.
  - Decrement logic is gated so a zero count is never decremented.
- Latency (PRESCALE=P, load_val=N>0, start sampled at edge 0):
  - cnt=N after edge 0.
  - cnt=N-k after edge k*P.
  - tc and done high after edge N*P.
  - Auto-reload period is N*P cycles.
- A reset assertion mid-count forces the reset state immediately, without waiting for a clock edge.
- Inputs are synchronous to clk. No internal synchronisers.

Test Plan:
- Reset asserted mid-RUN between edges -> cnt=0, state=IDLE, busy=0 immediately; clock edges during reset cause no change.
- PRESCALE=1, start with load_val=5, reload_mode=0 -> cnt 5,4,3,2,1,0 on consecutive edges; tc high exactly one cycle when cnt=0; done stays high; cnt never reaches 15.
- PRESCALE=3, load_val=2, reload_mode=1 -> cnt sequence 2,2,2,1,1,1,2,...; tc pulses every 6 cycles; state stays RUN.
- PRESCALE=1, load_val=4, pause high for 3 cycles after cnt=2, pause and decrement event coincident -> cnt holds 2 through HOLD; resumes 1,0 after release; total run time extended by exactly 3 cycles.
- Start with load_val=0 -> DONE next edge, tc one cycle, cnt=0. Then start with load_val=3 from DONE -> restarts, cnt=3, busy=1.
- abort asserted with start in RUN at cnt=7 (load_val=9) -> IDLE, cnt=0, tc=0; the start and its new load_val are not taken.
